// File: rtl/aes_gcm_tag_scheduler_if.sv
// ---------------------------------------------------------------------------
// aes_gcm_tag_scheduler_if
//
// Bundles the descriptor, block-stream, GHASH/tag stage and tag handoff
// signals of the GCM tag scheduler.
//
//   slave  : scheduler side (consumes i_*, drives o_*)
//   master : environment side (drives i_*, consumes o_*)
//
// Signal groups:
//   descriptor : i_cfg_valid, o_cfg_ready, i_aad_bits, i_text_bits
//   AAD stream : i_aad_valid, o_aad_ready, i_aad
//   CT stream  : i_ct_valid, o_ct_ready, i_ct
//   stage      : o_stage_new_instance, o_stage_aad, o_stage_cipher_text,
//                o_stage_instance_size, i_stage_tag_ready, i_stage_tag
//   tag out    : o_tag_valid, i_tag_ready, o_tag
//   status     : o_busy, o_err, o_err_code
// ---------------------------------------------------------------------------
interface aes_gcm_tag_scheduler_if #(
    parameter int LEN_W = 64
);
    logic             i_cfg_valid;
    logic             o_cfg_ready;
    logic [LEN_W-1:0] i_aad_bits;
    logic [LEN_W-1:0] i_text_bits;

    logic             i_aad_valid;
    logic             o_aad_ready;
    logic [127:0]     i_aad;

    logic             i_ct_valid;
    logic             o_ct_ready;
    logic [127:0]     i_ct;

    logic             o_stage_new_instance;
    logic [127:0]     o_stage_aad;
    logic [127:0]     o_stage_cipher_text;
    logic [127:0]     o_stage_instance_size;
    logic             i_stage_tag_ready;
    logic [127:0]     i_stage_tag;

    logic             o_tag_valid;
    logic             i_tag_ready;
    logic [127:0]     o_tag;

    logic             o_busy;
    logic             o_err;
    logic [1:0]       o_err_code;

    modport slave (
        input  i_cfg_valid, i_aad_bits, i_text_bits,
        input  i_aad_valid, i_aad,
        input  i_ct_valid, i_ct,
        input  i_stage_tag_ready, i_stage_tag,
        input  i_tag_ready,
        output o_cfg_ready,
        output o_aad_ready, o_ct_ready,
        output o_stage_new_instance, o_stage_aad, o_stage_cipher_text,
        output o_stage_instance_size,
        output o_tag_valid, o_tag,
        output o_busy, o_err, o_err_code
    );

    modport master (
        output i_cfg_valid, i_aad_bits, i_text_bits,
        output i_aad_valid, i_aad,
        output i_ct_valid, i_ct,
        output i_stage_tag_ready, i_stage_tag,
        output i_tag_ready,
        input  o_cfg_ready,
        input  o_aad_ready, o_ct_ready,
        input  o_stage_new_instance, o_stage_aad, o_stage_cipher_text,
        input  o_stage_instance_size,
        input  o_tag_valid, o_tag,
        input  o_busy, o_err, o_err_code
    );
endinterface

// File: rtl/aes_gcm_tag_scheduler.sv
// ---------------------------------------------------------------------------
// aes_gcm_tag_scheduler
//
// Feeds one GCM authentication instance at a time into a GHASH/tag stage
// whose block counter advances every cycle. After a length descriptor is
// accepted, the AAD blocks and then the ciphertext blocks are forwarded one
// per cycle with no bubbles, followed by a single length cycle. The stage tag
// is captured and held on a valid/ready handoff.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : aes_gcm_tag_scheduler_if.slave
//          - descriptor  i_cfg_valid / o_cfg_ready, i_aad_bits, i_text_bits
//          - AAD stream  i_aad_valid / o_aad_ready, i_aad
//          - CT stream   i_ct_valid / o_ct_ready, i_ct
//          - stage       o_stage_new_instance, o_stage_aad,
//                        o_stage_cipher_text, o_stage_instance_size
//                        ({text_bits, aad_bits}), i_stage_tag_ready,
//                        i_stage_tag
//          - tag handoff o_tag_valid / i_tag_ready, o_tag
//          - status      o_busy, o_err (one-cycle pulse), o_err_code
//                        (1 bad cfg, 2 stream underflow, 3 tag timeout)
// ---------------------------------------------------------------------------
module aes_gcm_tag_scheduler #(
    parameter int LEN_W    = 64,
    parameter int CNT_W    = 16,
    parameter int TAG_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_gcm_tag_scheduler_if.slave  bus
);

    localparam int SUM_W  = LEN_W - 6;
    localparam int WAIT_W = (TAG_WAIT < 2) ? 1 : $clog2(TAG_WAIT + 1);

    // The stage counter must still be able to tag the length block and the
    // cycle after it, so at most 2^CNT_W-2 data blocks fit in one instance.
    localparam logic [SUM_W-1:0] MAX_BLKS = SUM_W'({CNT_W{1'b1}}) - SUM_W'(1);

    localparam logic [1:0] ERR_CFG     = 2'd1;
    localparam logic [1:0] ERR_UNDERFL = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AAD,
        S_TEXT,
        S_LEN,
        S_WAIT_TAG,
        S_TAG_OUT
    } state_t;

    state_t             state, state_nx;
    logic [LEN_W-1:0]   aad_bits_q, text_bits_q;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_nx;
    logic               first_q, first_nx;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_nx;
    logic [127:0]       tag_q;
    logic [1:0]         err_code_q;

    logic               cfg_acc;
    logic               cfg_bad;
    logic               tag_cap;
    logic               err_det;
    logic [1:0]         err_det_code;
    logic [CNT_W-1:0]   cfg_aad_blks, cfg_ct_blks, ct_blks;

    // A descriptor is unusable when either length is not whole blocks or
    // when the combined block count would overrun the stage counter.
    function automatic logic cfg_is_bad(input logic [LEN_W-1:0] aad_bits,
                                        input logic [LEN_W-1:0] text_bits);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(aad_bits[LEN_W-1:7]) + SUM_W'(text_bits[LEN_W-1:7]);
        return (|aad_bits[6:0]) || (|text_bits[6:0]) || (sum > MAX_BLKS);
    endfunction

    assign cfg_bad      = cfg_is_bad(bus.i_aad_bits, bus.i_text_bits);
    // Truncation is safe: an accepted descriptor has A+C within CNT_W bits.
    assign cfg_aad_blks = CNT_W'(bus.i_aad_bits[LEN_W-1:7]);
    assign cfg_ct_blks  = CNT_W'(bus.i_text_bits[LEN_W-1:7]);
    assign ct_blks      = CNT_W'(text_bits_q[LEN_W-1:7]);

    // Next-state and stage-facing outputs
    always_comb begin
        state_nx     = state;
        blk_cnt_nx   = blk_cnt_q;
        first_nx     = first_q;
        wait_cnt_nx  = wait_cnt_q;
        cfg_acc      = 1'b0;
        tag_cap      = 1'b0;
        err_det      = 1'b0;
        err_det_code = 2'd0;

        bus.o_cfg_ready          = 1'b0;
        bus.o_aad_ready          = 1'b0;
        bus.o_ct_ready           = 1'b0;
        bus.o_stage_new_instance = 1'b0;
        bus.o_stage_aad          = '0;
        bus.o_stage_cipher_text  = '0;
        bus.o_tag_valid          = 1'b0;

        case (state)
            S_IDLE: begin
                bus.o_cfg_ready = 1'b1;
                if (bus.i_cfg_valid) begin
                    if (cfg_bad) begin
                        err_det      = 1'b1;
                        err_det_code = ERR_CFG;
                    end else begin
                        cfg_acc  = 1'b1;
                        first_nx = 1'b1;
                        if (cfg_aad_blks != '0) begin
                            state_nx   = S_AAD;
                            blk_cnt_nx = cfg_aad_blks;
                        end else if (cfg_ct_blks != '0) begin
                            state_nx   = S_TEXT;
                            blk_cnt_nx = cfg_ct_blks;
                        end else begin
                            state_nx = S_LEN;
                        end
                    end
                end
            end

            S_AAD: begin
                bus.o_aad_ready = 1'b1;
                if (bus.i_aad_valid) begin
                    bus.o_stage_aad          = bus.i_aad;
                    bus.o_stage_new_instance = first_q;
                    first_nx                 = 1'b0;
                    if (blk_cnt_q == CNT_W'(1)) begin
                        if (ct_blks != '0) begin
                            state_nx   = S_TEXT;
                            blk_cnt_nx = ct_blks;
                        end else begin
                            state_nx = S_LEN;
                        end
                    end else begin
                        blk_cnt_nx = blk_cnt_q - CNT_W'(1);
                    end
                end else begin
                    // A missing block would desynchronise the stage counter,
                    // so the whole instance is abandoned.
                    err_det      = 1'b1;
                    err_det_code = ERR_UNDERFL;
                    state_nx     = S_IDLE;
                end
            end

            S_TEXT: begin
                bus.o_ct_ready = 1'b1;
                if (bus.i_ct_valid) begin
                    bus.o_stage_cipher_text  = bus.i_ct;
                    bus.o_stage_new_instance = first_q;
                    first_nx                 = 1'b0;
                    if (blk_cnt_q == CNT_W'(1)) begin
                        state_nx = S_LEN;
                    end else begin
                        blk_cnt_nx = blk_cnt_q - CNT_W'(1);
                    end
                end else begin
                    err_det      = 1'b1;
                    err_det_code = ERR_UNDERFL;
                    state_nx     = S_IDLE;
                end
            end

            S_LEN: begin
                // An empty instance starts on the length block itself.
                bus.o_stage_new_instance = first_q;
                first_nx                 = 1'b0;
                wait_cnt_nx              = '0;
                state_nx                 = S_WAIT_TAG;
            end

            S_WAIT_TAG: begin
                if (bus.i_stage_tag_ready) begin
                    tag_cap  = 1'b1;
                    state_nx = S_TAG_OUT;
                end else if (wait_cnt_q == WAIT_W'(TAG_WAIT - 1)) begin
                    err_det      = 1'b1;
                    err_det_code = ERR_TIMEOUT;
                    state_nx     = S_IDLE;
                end else begin
                    wait_cnt_nx = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_TAG_OUT: begin
                bus.o_tag_valid = 1'b1;
                if (bus.i_tag_ready) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Status and captured values
    assign bus.o_busy                = (state != S_IDLE);
    assign bus.o_err                 = err_det;
    assign bus.o_err_code            = err_det ? err_det_code : err_code_q;
    assign bus.o_tag                 = tag_q;
    assign bus.o_stage_instance_size = {64'(text_bits_q), 64'(aad_bits_q)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            blk_cnt_q   <= '0;
            first_q     <= 1'b0;
            wait_cnt_q  <= '0;
            tag_q       <= '0;
            err_code_q  <= 2'd0;
            aad_bits_q  <= '0;
            text_bits_q <= '0;
        end else begin
            state      <= state_nx;
            blk_cnt_q  <= blk_cnt_nx;
            first_q    <= first_nx;
            wait_cnt_q <= wait_cnt_nx;
            if (tag_cap) begin
                tag_q <= bus.i_stage_tag;
            end
            if (err_det) begin
                err_code_q <= err_det_code;
            end
            if (cfg_acc) begin
                aad_bits_q  <= bus.i_aad_bits;
                text_bits_q <= bus.i_text_bits;
            end
        end
    end

endmodule
